// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner and 16-bit instruction fetch ahead of decode
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        inst_valid,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_squash_addr;
  logic [15:0] r_instruction;
  logic [15:0] r_pc_plus2;
  logic        r_inst_valid;
  logic        r_halted;
  logic        r_err;
  logic [3:0]  r_wait_cnt;

  logic        w_slot_free;
  logic        w_req;
  logic        w_capture;
  logic        w_accept;
  logic        w_halt_inst;
  logic [15:0] w_pc_next2;

  assign w_slot_free = ~r_inst_valid | ~stall;
  assign w_pc_next2  = r_pc + 16'd2;
  assign w_accept    = r_inst_valid & ~stall;
  assign w_halt_inst = w_accept & (r_instruction[15:11] == 5'b00000);
  assign w_capture   = ((r_state == S_FETCH) | (r_state == S_WAIT)) & w_slot_free & imem_ready;

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH:         w_req = w_slot_free;
      S_WAIT, S_SQUASH: w_req = 1'b1;
      default:         w_req = 1'b0;
    endcase
  end

  // A squashed read keeps its original address on the bus until memory answers,
  // so the memory never sees the address change under an outstanding request.
  assign imem_req    = w_req & ~rst;
  assign imem_addr   = (r_state == S_SQUASH) ? r_squash_addr : r_pc;
  assign instruction = r_instruction;
  assign pc_plus2    = r_pc_plus2;
  assign inst_valid  = r_inst_valid;
  assign halted      = r_halted;
  assign err         = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_squash_addr <= RESET_PC;
      r_instruction <= NOP_INST;
      r_pc_plus2    <= RESET_PC + 16'd2;
      r_inst_valid  <= 1'b0;
      r_halted      <= 1'b0;
      r_err         <= 1'b0;
      r_wait_cnt    <= 4'd0;
    end else if (r_state == S_HALT) begin
      r_inst_valid  <= 1'b0;
      r_instruction <= NOP_INST;
    end else if (redirect) begin
      r_pc          <= redirect_pc;
      r_inst_valid  <= 1'b0;
      r_instruction <= NOP_INST;
      if (redirect_pc[0]) begin
        r_err    <= 1'b1;
        r_halted <= 1'b1;
        r_state  <= S_HALT;
      end else begin
        case (r_state)
          S_FETCH, S_WAIT: begin
            if (w_req & ~imem_ready) begin
              r_state       <= S_SQUASH;
              r_squash_addr <= r_pc;
              r_wait_cnt    <= 4'd1;
            end else begin
              r_state    <= S_FETCH;
              r_wait_cnt <= 4'd0;
            end
          end
          S_SQUASH: begin
            if (imem_ready) begin
              r_state    <= S_FETCH;
              r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt == c_max_wait) begin
              r_err    <= 1'b1;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end else if (w_halt_inst) begin
      r_halted      <= 1'b1;
      r_state       <= S_HALT;
      r_inst_valid  <= 1'b0;
      r_instruction <= NOP_INST;
    end else begin
      if (w_capture) begin
        r_instruction <= imem_rdata;
        r_pc_plus2    <= w_pc_next2;
        r_pc          <= w_pc_next2;
        r_inst_valid  <= 1'b1;
      end else if (w_accept) begin
        r_inst_valid  <= 1'b0;
        r_instruction <= NOP_INST;
      end
      case (r_state)
        S_FETCH: begin
          if (w_slot_free & ~imem_ready) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 4'd1;
          end
        end
        S_WAIT, S_SQUASH: begin
          if (imem_ready) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 4'd0;
          end else if (r_wait_cnt == c_max_wait) begin
            r_err    <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
